// File: rtl/acc_core_param.sv
// Parametrised accumulator micro-core: A, register file, Z/C flags, byte-wide program RAM.
// Every instruction takes 3 cycles (FETCH, DECODE, EXECUTE); a load_we cycle freezes the whole core.
module acc_core_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   input  logic              start,
   output logic [DATA_W-1:0] acc_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic              halted,
   output logic              illegal
);

   typedef enum logic [1:0] {S_HALT, S_FETCH, S_DECODE, S_EXEC} state_t;

   localparam logic [4:0] NREG = 5'(NUM_REGS);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              z_q, z_d, c_q, c_d, ill_q, ill_d;
   logic [7:0]        op_q, op_d, opd_q, opd_d;
   // Sixteen slots so any 4-bit index is in range; slots >= NUM_REGS are never written.
   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];
   logic [7:0]        mem_q [2**ADDR_W];

   logic [3:0]        ridx;
   logic [DATA_W-1:0] imm, rsel, b_val, res, pc_step_unused;
   logic [DATA_W:0]   sum, diff;
   logic [ADDR_W-1:0] tgt;
   logic              two_byte, legal;

   assign ridx     = op_q[3:0];
   assign imm      = DATA_W'(opd_q);
   assign rsel     = regs_q[ridx];
   assign b_val    = (op_q[7:4] == 4'h0) ? imm : rsel;
   assign sum      = {1'b0, acc_q} + {1'b0, b_val};
   assign diff     = {1'b0, acc_q} - {1'b0, b_val};
   assign tgt      = ADDR_W'(opd_q);
   assign two_byte = ((op_q >= 8'h01) && (op_q <= 8'h06)) || ((op_q >= 8'h0B) && (op_q <= 8'h0F));
   assign legal    = (op_q[7:4] == 4'h0) ||
                     ((op_q[7:4] <= 4'h6) && ({1'b0, ridx} < NREG));
   assign pc_step_unused = '0;

   always_ff @(posedge clk) begin
      if (load_we) mem_q[load_addr] <= load_data;
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      pc_d    = pc_q;
      z_d     = z_q;
      c_d     = c_q;
      ill_d   = ill_q;
      op_d    = op_q;
      opd_d   = opd_q;
      regs_d  = regs_q;
      res     = '0;
      if (!load_we) begin
         unique case (state_q)
            S_HALT: begin
               if (start) begin
                  state_d = S_FETCH;
                  pc_d    = '0;
                  ill_d   = 1'b0;
               end
            end
            S_FETCH: begin
               op_d    = mem_q[pc_q];
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
            S_DECODE: begin
               if (two_byte) begin
                  opd_d = mem_q[pc_q];
                  pc_d  = pc_q + ADDR_W'(1);
               end
               state_d = S_EXEC;
            end
            default: begin
               state_d = S_FETCH;
               if (!legal) begin
                  state_d = S_HALT;
                  ill_d   = 1'b1;
               end else if (op_q[7:4] == 4'h0) begin
                  unique case (op_q[3:0])
                     4'h1: acc_d = imm;
                     4'h2: begin res = sum[DATA_W-1:0];  c_d = sum[DATA_W];  end
                     4'h3: begin res = diff[DATA_W-1:0]; c_d = diff[DATA_W]; end
                     4'h4: begin res = acc_q & imm; c_d = 1'b0; end
                     4'h5: begin res = acc_q | imm; c_d = 1'b0; end
                     4'h6: begin res = acc_q ^ imm; c_d = 1'b0; end
                     4'h7: res = ~acc_q;
                     4'h8: begin res = {acc_q[DATA_W-2:0], 1'b0}; c_d = acc_q[DATA_W-1]; end
                     4'h9: begin res = {1'b0, acc_q[DATA_W-1:1]}; c_d = acc_q[0]; end
                     4'hA: state_d = S_HALT;
                     4'hB: pc_d = tgt;
                     4'hC: if (z_q)  pc_d = tgt;
                     4'hD: if (!z_q) pc_d = tgt;
                     4'hE: if (c_q)  pc_d = tgt;
                     4'hF: if (!c_q) pc_d = tgt;
                     default: ;
                  endcase
                  if ((op_q[3:0] >= 4'h2) && (op_q[3:0] <= 4'h9)) begin
                     acc_d = res;
                     z_d   = (res == '0);
                  end
               end else begin
                  unique case (op_q[7:4])
                     4'h1: regs_d[ridx] = acc_q;
                     4'h2: acc_d = rsel;
                     4'h3: begin res = sum[DATA_W-1:0];  c_d = sum[DATA_W];  acc_d = res; end
                     4'h4: begin res = diff[DATA_W-1:0]; c_d = diff[DATA_W]; acc_d = res; end
                     4'h5: begin res = rsel + DATA_W'(1); regs_d[ridx] = res; end
                     default: begin res = rsel - DATA_W'(1); regs_d[ridx] = res; end
                  endcase
                  if (op_q[7:4] >= 4'h3) z_d = (res == '0);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_HALT;
         acc_q   <= '0;
         pc_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         ill_q   <= 1'b0;
         op_q    <= '0;
         opd_q   <= '0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         pc_q    <= pc_d;
         z_q     <= z_d;
         c_q     <= c_d;
         ill_q   <= ill_d;
         op_q    <= op_d;
         opd_q   <= opd_d;
         regs_q  <= regs_d;
      end
   end

   assign acc_out    = acc_q;
   assign pc_out     = pc_q;
   assign zero_flag  = z_q;
   assign carry_flag = c_q;
   assign halted     = (state_q == S_HALT);
   assign illegal    = ill_q;

endmodule

// File: tb/tb_acc_core_param.sv
// Bench for acc_core_param: per-feature tasks, expected snapshots queued per cycle and drained while running.
module tb_acc_core_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_we;
   logic [4:0] load_addr;
   logic [7:0] load_data;
   logic       start;
   logic [7:0] acc_out;
   logic [4:0] pc_out;
   logic       zero_flag, carry_flag, halted, illegal;

   int errors = 0;
   int checks = 0;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int         cyc;
      logic [7:0] acc;
      logic [4:0] pc;
      logic       z, c, h, il;
      string      name;
   } exp_t;
   exp_t sb[$];

   acc_core_param #(.DATA_W(8), .ADDR_W(5), .NUM_REGS(4)) dut (
      .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .start(start), .acc_out(acc_out), .pc_out(pc_out), .zero_flag(zero_flag),
      .carry_flag(carry_flag), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic load_prog(input int base, input bq_t p);
      foreach (p[i]) begin
         load_we   = 1'b1;
         load_addr = 5'(base + i);
         load_data = p[i];
         tick();
      end
      load_we = 1'b0;
   endtask

   task automatic expect_at(input int cyc, input logic [7:0] acc, input logic [4:0] pc,
                            input logic z, input logic c, input logic h, input logic il,
                            input string name);
      exp_t e;
      e.cyc = cyc; e.acc = acc; e.pc = pc; e.z = z; e.c = c; e.h = h; e.il = il; e.name = name;
      sb.push_back(e);
   endtask

   // Pulse start, then step max_cyc edges; edge number stall_at also carries a load_we write.
   task automatic run(input int max_cyc, input int stall_at);
      exp_t e;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c <= max_cyc; c++) begin
         if (c > 0) begin
            if (c == stall_at) begin
               load_we = 1'b1; load_addr = 5'd20; load_data = 8'hAA;
            end
            tick();
            load_we = 1'b0;
         end
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front();
            checks++;
            if ({acc_out, pc_out, zero_flag, carry_flag, halted, illegal} !==
                {e.acc, e.pc, e.z, e.c, e.h, e.il}) begin
               errors++;
               $display("FAIL %s cyc=%0d: got acc=%h pc=%0d z=%b c=%b h=%b il=%b, want acc=%h pc=%0d z=%b c=%b h=%b il=%b",
                        e.name, c, acc_out, pc_out, zero_flag, carry_flag, halted, illegal,
                        e.acc, e.pc, e.z, e.c, e.h, e.il);
            end
         end
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL sb_drain: %0d expected snapshots never reached", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if (acc_out !== 8'h00)   begin errors++; $display("FAIL reset_acc got=%h want=00", acc_out); end
      checks++; if (pc_out !== 5'd0)     begin errors++; $display("FAIL reset_pc got=%0d want=0", pc_out); end
      checks++; if (zero_flag !== 1'b0)  begin errors++; $display("FAIL reset_z got=%b want=0", zero_flag); end
      checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL reset_c got=%b want=0", carry_flag); end
      checks++; if (halted !== 1'b1)     begin errors++; $display("FAIL reset_halted got=%b want=1", halted); end
      checks++; if (illegal !== 1'b0)    begin errors++; $display("FAIL reset_illegal got=%b want=0", illegal); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      do_reset();
      load_prog(0, '{8'h01, 8'h05, 8'h02, 8'h03, 8'h0A});
      expect_at(3, 8'h05, 5'd2, 0, 0, 0, 0, "basic_ldi");
      expect_at(6, 8'h08, 5'd4, 0, 0, 0, 0, "basic_addi");
      expect_at(9, 8'h08, 5'd5, 0, 0, 1, 0, "basic_halt");
      run(9, 0);
   endtask

   task automatic test_carry();
      do_reset();
      load_prog(0, '{8'h01, 8'hFF, 8'h02, 8'h01, 8'h03, 8'h01, 8'h0A});
      expect_at(3,  8'hFF, 5'd2, 0, 0, 0, 0, "carry_ldi");
      expect_at(6,  8'h00, 5'd4, 1, 1, 0, 0, "carry_addi_wrap");
      expect_at(9,  8'hFF, 5'd6, 0, 1, 0, 0, "carry_subi_borrow");
      expect_at(12, 8'hFF, 5'd7, 0, 1, 1, 0, "carry_halt");
      run(12, 0);
   endtask

   task automatic test_logic();
      do_reset();
      load_prog(0, '{8'h01, 8'h81, 8'h09, 8'h07, 8'h08, 8'h05, 8'h01, 8'h06, 8'h7F, 8'h0A});
      expect_at(3,  8'h81, 5'd2,  0, 0, 0, 0, "logic_ldi");
      expect_at(6,  8'h40, 5'd3,  0, 1, 0, 0, "logic_shr");
      expect_at(9,  8'hBF, 5'd4,  0, 1, 0, 0, "logic_not_keeps_c");
      expect_at(12, 8'h7E, 5'd5,  0, 1, 0, 0, "logic_shl");
      expect_at(15, 8'h7F, 5'd7,  0, 0, 0, 0, "logic_ori");
      expect_at(18, 8'h00, 5'd9,  1, 0, 0, 0, "logic_xori_zero");
      expect_at(21, 8'h00, 5'd10, 1, 0, 1, 0, "logic_halt");
      run(21, 0);
   endtask

   task automatic test_regs();
      do_reset();
      load_prog(0, '{8'h01, 8'h05, 8'h11, 8'h52, 8'h42, 8'h41, 8'h31, 8'h0A});
      expect_at(6,  8'h05, 5'd3, 0, 0, 0, 0, "regs_mov_r1");
      expect_at(9,  8'h05, 5'd4, 0, 0, 0, 0, "regs_inr_r2");
      expect_at(12, 8'h04, 5'd5, 0, 0, 0, 0, "regs_sub_r2");
      expect_at(15, 8'hFF, 5'd6, 0, 1, 0, 0, "regs_sub_r1_borrow");
      expect_at(18, 8'h04, 5'd7, 0, 1, 0, 0, "regs_add_r1_carry");
      expect_at(21, 8'h04, 5'd8, 0, 1, 1, 0, "regs_halt");
      run(21, 0);
   endtask

   task automatic test_loop();
      do_reset();
      load_prog(0, '{8'h01, 8'h03, 8'h10, 8'h60, 8'h0D, 8'h03, 8'h20, 8'h0A});
      expect_at(3, 8'h03, 5'd2, 0, 0, 0, 0, "loop_ldi");
      expect_at(6, 8'h03, 5'd3, 0, 0, 0, 0, "loop_mov_r0");
      for (int i = 0; i < 3; i++) begin
         expect_at(9 + 6*i, 8'h03, 5'd4, (i == 2), 0, 0, 0, $sformatf("loop_dcr_%0d", i));
         expect_at(12 + 6*i, 8'h03, (i == 2) ? 5'd6 : 5'd3, (i == 2), 0, 0, 0,
                   (i == 2) ? "loop_jnz_fall" : $sformatf("loop_jnz_taken_%0d", i));
      end
      expect_at(27, 8'h00, 5'd7, 1, 0, 0, 0, "loop_mov_a_r0");
      expect_at(30, 8'h00, 5'd8, 1, 0, 1, 0, "loop_halt");
      run(30, 0);
   endtask

   task automatic test_illegal();
      do_reset();
      load_prog(0, '{8'h01, 8'h42, 8'h7F});
      expect_at(3, 8'h42, 5'd2, 0, 0, 0, 0, "ill_ldi");
      expect_at(6, 8'h42, 5'd3, 0, 0, 1, 1, "ill_7f_trap");
      run(6, 0);
      load_prog(0, '{8'h15});
      expect_at(0, 8'h42, 5'd0, 0, 0, 0, 0, "ill_start_clears");
      expect_at(3, 8'h42, 5'd1, 0, 0, 1, 1, "ill_r5_trap");
      run(3, 0);
      load_prog(0, '{8'h0A});
      expect_at(0, 8'h42, 5'd0, 0, 0, 0, 0, "ill_restart");
      expect_at(3, 8'h42, 5'd1, 0, 0, 1, 0, "ill_clean_halt");
      run(3, 0);
   endtask

   task automatic test_wrap();
      do_reset();
      load_prog(0, '{8'h0B, 8'h1F});
      load_prog(31, '{8'h01});
      expect_at(3, 8'h00, 5'd31, 0, 0, 0, 0, "wrap_jmp");
      expect_at(6, 8'h0B, 5'd1,  0, 0, 0, 0, "wrap_operand_addr0");
      expect_at(9, 8'h0B, 5'd2,  0, 0, 1, 1, "wrap_then_r15_trap");
      run(9, 0);
   endtask

   task automatic test_stall();
      do_reset();
      load_prog(0, '{8'h01, 8'h05, 8'h02, 8'h03, 8'h0A});
      expect_at(2,  8'h00, 5'd2, 0, 0, 0, 0, "stall_decoded");
      expect_at(3,  8'h00, 5'd2, 0, 0, 0, 0, "stall_frozen_exec");
      expect_at(4,  8'h05, 5'd2, 0, 0, 0, 0, "stall_resumed");
      expect_at(7,  8'h08, 5'd4, 0, 0, 0, 0, "stall_addi");
      expect_at(10, 8'h08, 5'd5, 0, 0, 1, 0, "stall_halt");
      run(10, 3);
   endtask

   task automatic test_start_load_collision();
      do_reset();
      load_we = 1'b1; load_addr = 5'd0; load_data = 8'h0A; start = 1'b1;
      tick();
      load_we = 1'b0; start = 1'b0;
      checks++;
      if (halted !== 1'b1) begin errors++; $display("FAIL collide_start_dropped got halted=%b want=1", halted); end
      expect_at(3, 8'h00, 5'd1, 0, 0, 1, 0, "collide_load_written");
      run(3, 0);
   endtask

   task automatic test_async_reset();
      do_reset();
      load_prog(0, '{8'h01, 8'h05, 8'h02, 8'h03, 8'h0A});
      expect_at(3, 8'h05, 5'd2, 0, 0, 0, 0, "arst_pre_ldi");
      run(4, 0);
      rst = 1'b1;
      #1;
      checks++;
      if ({acc_out, pc_out, zero_flag, carry_flag, halted, illegal} !== {8'h00, 5'd0, 4'b0010}) begin
         errors++;
         $display("FAIL arst_immediate got acc=%h pc=%0d z=%b c=%b h=%b il=%b want acc=00 pc=0 z=0 c=0 h=1 il=0",
                  acc_out, pc_out, zero_flag, carry_flag, halted, illegal);
      end
      #2;
      rst = 1'b0;
      tick();
      expect_at(3, 8'h05, 5'd2, 0, 0, 0, 0, "arst_rerun_ldi");
      expect_at(6, 8'h08, 5'd4, 0, 0, 0, 0, "arst_rerun_addi");
      expect_at(9, 8'h08, 5'd5, 0, 0, 1, 0, "arst_rerun_halt");
      run(9, 0);
   endtask

   initial begin
      rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_logic();
      test_regs();
      test_loop();
      test_illegal();
      test_wrap();
      test_stall();
      test_start_load_collision();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
